regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 198 +++++++++++++++++++
 tb/tb_regfile_mp.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a byte-masked write port and a
// post-reset hardware clear sequence.
//
// Parameters
//   WIDTH    data word width in bits (multiple of 8)
//   DEPTH    number of registers (2..256)
//   NREAD    number of independent read ports (1..4)
//   ZERO_REG when 1, register 0 always reads as zero and ignores writes
//
// Ports
//   clk            single clock, all state updates on the rising edge
//   rst            synchronous active-high reset; restarts the clear sequence
//   read_register  NREAD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   read_en        per-port read strobe
//   write_register write address
//   reg_write      write strobe
//   write_mask     byte enables, bit b covers write_data[8b+7:8b]
//   write_data     write data
//   read_data      registered read data, port i at [i*WIDTH +: WIDTH]
//   read_valid     per-port flag, read_data for that port updated this cycle
//   busy           high while the post-reset clear sequence runs
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*ADDR_W-1:0] read_register,
    input  logic [NREAD-1:0]        read_en,
    input  logic [ADDR_W-1:0]       write_register,
    input  logic                    reg_write,
    input  logic [WIDTH/8-1:0]      write_mask,
    input  logic [WIDTH-1:0]        write_data,
    output logic [NREAD*WIDTH-1:0]  read_data,
    output logic [NREAD-1:0]        read_valid,
    output logic                    busy
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                   state_r;
    logic [ADDR_W-1:0]        clr_cnt_r;
    logic                     busy_r;
    logic [WIDTH-1:0]         mem_r [DEPTH];
    logic [NREAD*WIDTH-1:0]   read_data_r;
    logic [NREAD-1:0]         read_valid_r;

    logic                     wr_accept_s;
    logic [WIDTH-1:0]         wr_merged_s;
    logic                     mem_we_s;
    logic [ADDR_W-1:0]        mem_waddr_s;
    logic [WIDTH-1:0]         mem_wdata_s;
    logic [ADDR_W-1:0]        rd_addr_s  [NREAD];
    logic [WIDTH-1:0]         rd_value_s [NREAD];

    // True when the address maps onto a physical entry (DEPTH need not be a power of two).
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < (ADDR_W+1)'(DEPTH));
    endfunction

    // True when the address is the hardwired zero register.
    function automatic logic addr_is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
    endfunction

    // Byte-wise merge: new bytes where the mask is set, old bytes elsewhere.
    function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0]   old_word,
                                                     input logic [WIDTH-1:0]   new_word,
                                                     input logic [WIDTH/8-1:0] mask);
        logic [WIDTH-1:0] result;
        result = old_word;
        for (int b = 0; b < WIDTH / 8; b++) begin
            if (mask[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                result[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return result;
    endfunction

    // Unpack the per-port read addresses.
    for (genvar i = 0; i < NREAD; i++) begin : g_rd_addr
        assign rd_addr_s[i] = read_register[i*ADDR_W +: ADDR_W];
    end

    // Write acceptance and the single memory write port (clear engine or user write).
    always_comb begin
        wr_accept_s = 1'b0;
        wr_merged_s = merge_bytes(mem_r[write_register], write_data, write_mask);
        mem_we_s    = 1'b0;
        mem_waddr_s = {ADDR_W{1'b0}};
        mem_wdata_s = {WIDTH{1'b0}};
        // A write coincident with rst is discarded.
        if ((state_r == ST_READY) && !rst && reg_write &&
            addr_in_range(write_register) && !addr_is_zero_reg(write_register)) begin
            wr_accept_s = 1'b1;
        end else begin
            wr_accept_s = 1'b0;
        end
        if (state_r == ST_CLEAR) begin
            // Hold off while rst is high so only the restarted count clears entries.
            mem_we_s    = ~rst;
            mem_waddr_s = clr_cnt_r;
            mem_wdata_s = {WIDTH{1'b0}};
        end else begin
            mem_we_s    = wr_accept_s;
            mem_waddr_s = write_register;
            mem_wdata_s = wr_merged_s;
        end
    end

    // Per-port read value including zero/out-of-range handling and write-through bypass.
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            rd_value_s[i] = {WIDTH{1'b0}};
            if (!addr_in_range(rd_addr_s[i]) || addr_is_zero_reg(rd_addr_s[i])) begin
                rd_value_s[i] = {WIDTH{1'b0}};
            end else if (wr_accept_s && (rd_addr_s[i] == write_register)) begin
                rd_value_s[i] = wr_merged_s;
            end else begin
                rd_value_s[i] = mem_r[rd_addr_s[i]];
            end
        end
    end

    // Storage array; contents are defined only by the clear sequence and writes.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // CLEAR/READY state machine with the clear counter and registered busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= {ADDR_W{1'b0}};
            busy_r    <= 1'b1;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (clr_cnt_r == ADDR_W'(DEPTH - 1)) begin
                        state_r   <= ST_READY;
                        clr_cnt_r <= {ADDR_W{1'b0}};
                        busy_r    <= 1'b0;
                    end else begin
                        state_r   <= ST_CLEAR;
                        clr_cnt_r <= clr_cnt_r + 1'b1;
                        busy_r    <= 1'b1;
                    end
                end
                ST_READY: begin
                    state_r   <= ST_READY;
                    clr_cnt_r <= clr_cnt_r;
                    busy_r    <= 1'b0;
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_cnt_r <= {ADDR_W{1'b0}};
                    busy_r    <= 1'b1;
                end
            endcase
        end
    end

    // Read data/valid registers; data holds when a port is not strobed.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_r  <= {(NREAD*WIDTH){1'b0}};
            read_valid_r <= {NREAD{1'b0}};
        end else if (state_r == ST_READY) begin
            for (int i = 0; i < NREAD; i++) begin
                if (read_en[i]) begin
                    read_data_r[i*WIDTH +: WIDTH] <= rd_value_s[i];
                    read_valid_r[i]               <= 1'b1;
                end else begin
                    read_data_r[i*WIDTH +: WIDTH] <= read_data_r[i*WIDTH +: WIDTH];
                    read_valid_r[i]               <= 1'b0;
                end
            end
        end else begin
            read_data_r  <= read_data_r;
            read_valid_r <= {NREAD{1'b0}};
        end
    end

    assign read_data  = read_data_r;
    assign read_valid = read_valid_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp. Two instances share all inputs:
//   dut_a: DEPTH=32, ZERO_REG=1 (defaults)
//   dut_b: DEPTH=24, ZERO_REG=0 (same 5-bit address width)
// Stimulus pushes hand-computed expected read data per instance/port; a
// monitor pops and compares whenever read_valid is seen.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [9:0]  read_register;
    logic [1:0]  read_en;
    logic [4:0]  write_register;
    logic        reg_write;
    logic [3:0]  write_mask;
    logic [31:0] write_data;

    logic [63:0] rd_a, rd_b;
    logic [1:0]  rv_a, rv_b;
    logic        busy_a, busy_b;

    int errors = 0;
    int checks = 0;

    logic [31:0] qa0[$];
    logic [31:0] qa1[$];
    logic [31:0] qb0[$];
    logic [31:0] qb1[$];

    regfile_mp dut_a (
        .clk(clk), .rst(rst), .read_register(read_register), .read_en(read_en),
        .write_register(write_register), .reg_write(reg_write), .write_mask(write_mask),
        .write_data(write_data), .read_data(rd_a), .read_valid(rv_a), .busy(busy_a)
    );

    regfile_mp #(.DEPTH(24), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .read_register(read_register), .read_en(read_en),
        .write_register(write_register), .reg_write(reg_write), .write_mask(write_mask),
        .write_data(write_data), .read_data(rd_b), .read_valid(rv_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got read_valid=1 expected no read pending", name);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rv_a[0]) begin
            if (qa0.size() == 0) unexpected("a.port0");
            else check("a.port0", rd_a[31:0], qa0.pop_front());
        end
        if (rv_a[1]) begin
            if (qa1.size() == 0) unexpected("a.port1");
            else check("a.port1", rd_a[63:32], qa1.pop_front());
        end
        if (rv_b[0]) begin
            if (qb0.size() == 0) unexpected("b.port0");
            else check("b.port0", rd_b[31:0], qb0.pop_front());
        end
        if (rv_b[1]) begin
            if (qb1.size() == 0) unexpected("b.port1");
            else check("b.port1", rd_b[63:32], qb1.pop_front());
        end
    end

    // One clock of stimulus; expected read data is queued for enabled ports.
    task automatic issue(input logic we, input logic [4:0] wa, input logic [3:0] wm,
                         input logic [31:0] wd, input logic [1:0] re,
                         input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic [31:0] ea0, input logic [31:0] ea1,
                         input logic [31:0] eb0, input logic [31:0] eb1);
        reg_write      = we;
        write_register = wa;
        write_mask     = wm;
        write_data     = wd;
        read_en        = re;
        read_register  = {ra1, ra0};
        if (re[0]) begin
            qa0.push_back(ea0);
            qb0.push_back(eb0);
        end
        if (re[1]) begin
            qa1.push_back(ea1);
            qb1.push_back(eb1);
        end
        @(posedge clk);
        #2;
        reg_write = 1'b0;
        read_en   = 2'b00;
    endtask

    // Count edges after rst release until busy drops, for both instances.
    task automatic count_clear();
        int na;
        int nb;
        na = -1;
        nb = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #2;
            if (n == 3) begin
                reg_write = 1'b0;
                read_en   = 2'b00;
            end
            if (na < 0 && !busy_a) na = n;
            if (nb < 0 && !busy_b) nb = n;
            if (na >= 0 && nb >= 0) break;
        end
        check("a.clear_cycles", na, 32);
        check("b.clear_cycles", nb, 24);
    endtask

    initial begin
        rst            = 1'b1;
        read_register  = 10'd0;
        read_en        = 2'b00;
        write_register = 5'd0;
        reg_write      = 1'b0;
        write_mask     = 4'h0;
        write_data     = 32'h0;
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        check("a.reset_busy", {31'd0, busy_a}, 32'd1);
        check("b.reset_busy", {31'd0, busy_b}, 32'd1);
        check("a.reset_valid", {30'd0, rv_a}, 32'd0);
        check("a.reset_data", rd_a[31:0] | rd_a[63:32], 32'd0);
        check("b.reset_data", rd_b[31:0] | rd_b[63:32], 32'd0);

        // Strobes during the first CLEAR cycles must be ignored.
        reg_write      = 1'b1;
        write_register = 5'd3;
        write_mask     = 4'hF;
        write_data     = 32'hFFFF_FFFF;
        read_en        = 2'b11;
        read_register  = {5'd3, 5'd3};
        rst            = 1'b0;
        check("a.busy_at_release", {31'd0, busy_a}, 32'd1);
        count_clear();

        // Every address reads zero after the clear (out-of-range on b also zero).
        for (int i = 0; i < 32; i++) begin
            issue(1'b0, 5'd0, 4'h0, 32'h0, 2'b11, 5'(i), 5'(31 - i),
                  32'h0, 32'h0, 32'h0, 32'h0);
        end

        // Full write then dual-port read.
        issue(1'b1, 5'd5, 4'hF, 32'hDEAD_BEEF, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        issue(1'b0, 5'd0, 4'h0, 32'h0, 2'b11, 5'd5, 5'd5,
              32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        issue(1'b0, 5'd0, 4'h0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        check("a.hold_data", rd_a[31:0], 32'hDEAD_BEEF);
        check("a.hold_valid", {30'd0, rv_a}, 32'd0);

        // Masked write with same-edge bypass read, then stored value.
        issue(1'b1, 5'd5, 4'h5, 32'h1122_3344, 2'b11, 5'd5, 5'd5,
              32'hDE22_BE44, 32'hDE22_BE44, 32'hDE22_BE44, 32'hDE22_BE44);
        issue(1'b0, 5'd0, 4'h0, 32'h0, 2'b10, 5'd0, 5'd5,
              32'h0, 32'hDE22_BE44, 32'h0, 32'hDE22_BE44);

        // Register 0: hardwired on a, ordinary on b.
        issue(1'b1, 5'd0, 4'hF, 32'hFFFF_FFFF, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        issue(1'b0, 5'd0, 4'h0, 32'h0, 2'b01, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0);

        // Address 30: in range on a (bypass), out of range on b (dropped, reads 0).
        issue(1'b1, 5'd30, 4'hF, 32'h1234_5678, 2'b01, 5'd30, 5'd0,
              32'h1234_5678, 32'h0, 32'h0, 32'h0);
        issue(1'b0, 5'd0, 4'h0, 32'h0, 2'b11, 5'd30, 5'd14, 32'h1234_5678, 32'h0, 32'h0, 32'h0);
        issue(1'b0, 5'd0, 4'h0, 32'h0, 2'b11, 5'd6, 5'd5,
              32'h0, 32'hDE22_BE44, 32'h0, 32'hDE22_BE44);

        // Zero mask: entry unchanged, bypass returns the old value.
        issue(1'b1, 5'd5, 4'h0, 32'hFFFF_FFFF, 2'b01, 5'd5, 5'd0,
              32'hDE22_BE44, 32'h0, 32'hDE22_BE44, 32'h0);
        issue(1'b0, 5'd0, 4'h0, 32'h0, 2'b11, 5'd5, 5'd5,
              32'hDE22_BE44, 32'hDE22_BE44, 32'hDE22_BE44, 32'hDE22_BE44);

        // r7 set, then reset restarted mid-CLEAR.
        issue(1'b1, 5'd7, 4'hF, 32'hA5A5_A5A5, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        issue(1'b0, 5'd0, 4'h0, 32'h0, 2'b10, 5'd0, 5'd7,
              32'h0, 32'hA5A5_A5A5, 32'h0, 32'hA5A5_A5A5);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #2;
        end
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("a.reset_mid_clear_data", rd_a[63:32], 32'd0);
        rst = 1'b0;
        count_clear();
        issue(1'b0, 5'd0, 4'h0, 32'h0, 2'b11, 5'd7, 5'd5, 32'h0, 32'h0, 32'h0, 32'h0);
        issue(1'b0, 5'd0, 4'h0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);

        // Every queued read must have been answered.
        check("a.port0_pending", qa0.size(), 32'd0);
        check("a.port1_pending", qa1.size(), 32'd0);
        check("b.port0_pending", qb0.size(), 32'd0);
        check("b.port1_pending", qb1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
